regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable).
REQ-003 Parameter N_RD, 2, number of read ports (1..4).
REQ-004 Parameter ZERO_R0, 1, 1 = entry 0 hardwired to zero.
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rs_addr  in  N_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 rv  out  N_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-010 wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  write port A.
REQ-011 wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write port B.
REQ-012 clr_req  in  1  request bulk clear of all entries.
REQ-013 busy  out  1  clear sequence in progress.
REQ-014 clr_done  out  1  one-cycle pulse when clear sequence completes.

Function
REQ-015 Reads SHALL be combinational from rs_addr to rv, zero-cycle latency.
REQ-016 Enabled writes SHALL update the addressed entry at the rising edge; visible on rv the following cycle.
REQ-017 Both ports writing the same address in one cycle SHALL store wb_data (B has priority); different addresses SHALL both be written.
REQ-018 With ZERO_R0=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded, including for bypass.
REQ-019 With BYPASS=1 and busy=0, a read whose address matches an enabled write SHALL return that write's data in the same cycle, B over A.
REQ-020 With BYPASS=0, reads SHALL return stored contents only.
REQ-021 Clear engine states: IDLE, CLEAR; counter cnt of ADDR_W bits.
REQ-022 IDLE -> CLEAR when clr_req=1; cnt set to 0.
REQ-023 In CLEAR each cycle SHALL write 0 to entry cnt and increment cnt; at cnt=DEPTH-1 the write SHALL occur and next state SHALL be IDLE.
REQ-024 clr_done SHALL be 1 for exactly the first IDLE cycle after CLEAR; clear takes exactly DEPTH cycles of busy=1.
REQ-025 busy SHALL be 1 exactly while in CLEAR.
REQ-026 While busy=1, wa_en/wb_en SHALL be ignored (no storage, no bypass) and all rv ports SHALL read 0.
REQ-027 clr_req while busy=1 SHALL be ignored (no restart, no extension).
REQ-028 clr_req asserted in the clr_done cycle SHALL start a new clear the next cycle, with clr_done still pulsing.

Reset
REQ-029 rst=1 at a rising edge SHALL set state=CLEAR, cnt=0, clr_done=0, overriding any operation in progress, including mid-clear.
REQ-030 After rst deasserts, the full DEPTH-cycle clear SHALL run; every entry reads 0 once busy falls.
REQ-031 While rst=1, busy SHALL be 1, rv SHALL be 0, and writes SHALL be ignored.

Structure
REQ-032 Shared package regfile_pkg SHALL hold the clear-state enum (IDLE, CLEAR) and default DATA_W/ADDR_W constants.
REQ-033 Clear FSM and counter SHALL be the sub-module regfile_clr_seq, outputting busy, clr_done, clear address, clear write-enable.
REQ-034 Storage SHALL be one DEPTH x DATA_W array with no per-entry reset.

Verification
REQ-035 rst 1 cycle, release -> busy=1 for 32 cycles, clr_done pulse on cycle 33, all 32 entries read 0.
REQ-036 wa writes 0xDEADBEEF to r5 and wb writes 0x12345678 to r5 in the same cycle -> r5 reads 0x12345678 next cycle; same-cycle rs_addr=5 bypass returns 0x12345678.
REQ-037 Write 0xFFFFFFFF to r0 (ZERO_R0=1) with rs_addr=0 -> rv=0 in the write cycle and after.
REQ-038 Fill r1..r31 with their index; clr_req pulse -> rv=0 during busy; wa write to r7 during busy ignored; after clr_done all entries read 0.
REQ-039 clr_req held high continuously -> back-to-back clears, busy low only in the clr_done cycle, clr_done every 33 cycles.
REQ-040 rst asserted at cnt=10 mid-clear -> cnt restarts at 0, full 32-cycle clear follows, single clr_done at end.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-state enum and default widths for the register file
package regfile_pkg;
    typedef enum logic {IDLE, CLEAR} clr_state_e;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: bulk-clear sequencer sweeping every entry once per clear
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);
    localparam logic [ADDR_W-1:0] LAST = '1;
    clr_state_e        state, nxt;
    logic [ADDR_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= (state == CLEAR) ? cnt + 1'b1 : '0;
            clr_done <= (state == CLEAR) && (cnt == LAST);
        end
    end
    always_comb begin
        nxt = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : ((cnt == LAST) ? IDLE : CLEAR);
    end
    // busy covers the reset cycles themselves, before the state register settles
    assign busy     = rst || (state == CLEAR);
    assign clr_we   = !rst && (state == CLEAR);
    assign clr_addr = cnt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with forwarding and bulk clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_RD    = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*ADDR_W-1:0] rs_addr,
    output logic [N_RD*DATA_W-1:0] rv,
    input  logic                   wa_en,
    input  logic [ADDR_W-1:0]      wa_addr,
    input  logic [DATA_W-1:0]      wa_data,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   clr_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we, wa_ok, wb_ok;
    regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_done(clr_done),
        .clr_addr(clr_addr),
        .clr_we  (clr_we)
    );
    assign wa_ok = wa_en && !busy && !(ZERO_R0 != 0 && wa_addr == '0);
    assign wb_ok = wb_en && !busy && !(ZERO_R0 != 0 && wb_addr == '0);
    // B is written last so it wins on an address collision
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rs_addr[k*ADDR_W +: ADDR_W];
        assign rv[k*DATA_W +: DATA_W] =
            (busy || (ZERO_R0 != 0 && a == '0))      ? '0 :
            (BYPASS != 0 && wb_ok && wb_addr == a)    ? wb_data :
            (BYPASS != 0 && wa_ok && wa_addr == a)    ? wa_data :
                                                        mem[a];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp against a behavioural model
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 2;
    logic             clk = 1'b0, rst = 1'b1;
    logic [NR*AW-1:0] rs_addr = '0;
    logic [NR*DW-1:0] rv;
    logic             wa_en = 1'b0, wb_en = 1'b0, clr_req = 1'b0;
    logic [AW-1:0]    wa_addr = '0, wb_addr = '0;
    logic [DW-1:0]    wa_data = '0, wb_data = '0;
    logic             busy, clr_done;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rv(rv),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] m [32];
    bit          mclr, mdone;
    int          mcnt;
    logic [65:0] sb [$];
    logic [63:0] orv;
    logic        ob, od;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (rst || mclr || a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m[a];
    endfunction

    task automatic cycle();
        logic [65:0] e;
        sb.push_back({exp_rd(rs_addr[9:5]), exp_rd(rs_addr[4:0]), rst || mclr, mdone});
        @(negedge clk);
        orv = rv;
        ob  = busy;
        od  = clr_done;
        e   = sb.pop_front();
        chk("rv0", {32'd0, orv[31:0]}, {32'd0, e[33:2]});
        chk("rv1", {32'd0, orv[63:32]}, {32'd0, e[65:34]});
        chk("busy", {63'd0, ob}, {63'd0, e[1]});
        chk("clr_done", {63'd0, od}, {63'd0, e[0]});
        @(posedge clk);
        if (rst) begin
            mclr = 1; mcnt = 0; mdone = 0;
        end else if (mclr) begin
            m[mcnt] = 32'd0;
            mdone = (mcnt == 31);
            if (mcnt == 31) mclr = 0;
            mcnt = (mcnt + 1) % 32;
        end else begin
            mdone = 0;
            if (wa_en && wa_addr != 0) m[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m[wb_addr] = wb_data;
            if (clr_req) begin mclr = 1; mcnt = 0; end
        end
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; clr_req = 0; rst = 0;
    endtask

    task automatic wait_done(output int n, output int nb);
        n = 0; nb = 0; od = 0;
        while (!od && n < 100) begin
            cycle();
            n++;
            if (ob) nb++;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            rs_addr = {5'(31 - a), 5'(a)};
            cycle();
            chk("cleared", {32'd0, orv[31:0]}, 64'd0);
        end
    endtask

    initial begin
        int n, nb, nd, first, lowb;
        for (int i = 0; i < 32; i++) m[i] = $urandom | 32'h1;
        @(posedge clk); #1;
        mclr = 1; mcnt = 0; mdone = 0;
        idle();
        wait_done(n, nb);
        chk("rst_busy_len", 64'(nb), 64'd32);
        chk("rst_done_cyc", 64'(n), 64'd33);
        read_all();

        wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF;
        wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
        rs_addr = {5'd5, 5'd5};
        cycle();
        chk("byp_b_over_a", {32'd0, orv[31:0]}, 64'h12345678);
        idle();
        cycle();
        chk("r5_store_b", {32'd0, orv[31:0]}, 64'h12345678);
        wa_en = 1; wa_addr = 3; wa_data = 32'hA5A5_0003;
        wb_en = 1; wb_addr = 4; wb_data = 32'h5A5A_0004;
        rs_addr = {5'd4, 5'd3};
        cycle();
        idle();
        cycle();
        chk("r3_a", {32'd0, orv[31:0]}, 64'hA5A50003);

        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
        rs_addr = {5'd0, 5'd0};
        cycle();
        chk("r0_wcyc", {32'd0, orv[31:0]}, 64'd0);
        idle();
        cycle();
        chk("r0_after", {32'd0, orv[63:32]}, 64'd0);

        for (int i = 1; i < 32; i += 2) begin
            wa_en = 1; wa_addr = 5'(i); wa_data = 32'(i);
            wb_en = (i < 31); wb_addr = 5'(i + 1); wb_data = 32'(i + 1);
            rs_addr = {5'(i + 1), 5'(i)};
            cycle();
        end
        idle();
        for (int a = 1; a < 32; a += 6) begin
            rs_addr = {5'd0, 5'(a)};
            cycle();
        end
        clr_req = 1;
        rs_addr = {5'd7, 5'd9};
        cycle();
        clr_req = 0;
        wa_en = 1; wa_addr = 7; wa_data = 32'hBAD0BAD0;
        rs_addr = {5'd9, 5'd7};
        cycle();
        chk("busy_rv_zero", orv, 64'd0);
        wa_en = 0;
        wait_done(n, nb);
        chk("clr_busy_len", 64'(nb), 64'd31);
        read_all();
        rs_addr = {5'd0, 5'd7};
        cycle();
        chk("r7_ignored", {32'd0, orv[31:0]}, 64'd0);

        clr_req = 1;
        nd = 0; first = 0; lowb = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (od) begin
                nd++;
                if (first == 0) first = i;
                else chk("b2b_period", 64'((i - first) % 33), 64'd0);
            end
            if (i > 0 && !ob) lowb++;
        end
        chk("b2b_dones", 64'(nd), 64'd3);
        chk("b2b_first", 64'(first), 64'd33);
        chk("b2b_low_busy", 64'(lowb), 64'(nd));
        clr_req = 0;
        wait_done(n, nb);
        chk("b2b_tail", 64'(n), 64'd33);

        clr_req = 1;
        cycle();
        clr_req = 0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (od) nd++;
        end
        rst = 1;
        cycle();
        chk("rst_busy", {63'd0, ob}, 64'd1);
        rst = 0;
        wait_done(n, nb);
        chk("mid_rst_busy", 64'(nb), 64'd32);
        chk("mid_rst_done_cyc", 64'(n), 64'd33);
        chk("mid_rst_no_early_done", 64'(nd), 64'd0);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
